// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//   Shared definitions for the PWM dead-time inserter.
//   - D_DEFAULT : default width of the dead-time value (clock cycles).
//   - state_t   : per-channel FSM state encoding.
//   S_FAULT is only reachable when PWM_DEADTIME_FAULT_EN is defined.
// ---------------------------------------------------------------------------
package pwm_pkg;

  localparam int unsigned D_DEFAULT = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_INIT  = 3'd0;
  localparam state_t S_LO    = 3'd1;
  localparam state_t S_DT_H  = 3'd2;
  localparam state_t S_HI    = 3'd3;
  localparam state_t S_DT_L  = 3'd4;
  localparam state_t S_FAULT = 3'd5;

endpackage

// File: rtl/pwm_deadtime_ch.sv
// ---------------------------------------------------------------------------
// pwm_deadtime_ch
//   One dead-time channel: FSM plus a D-bit down-counter.
//   Turns a raw PWM bit into complementary, registered hi/lo gate enables
//   with a dead-cycle gap on every commutation.
//
//   Optional feature macro: PWM_DEADTIME_FAULT_EN (adds trip/clr inputs and
//   the S_FAULT state).
//
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     trip   in   synchronised fault (fault build only), overrides everything
//     clr    in   qualified fault clear (fault build only)
//     pwm    in   raw PWM bit for this channel
//     dead   in   dead time in cycles, sampled only when the counter loads
//     hi     out  high-side enable, registered
//     lo     out  low-side enable, registered
//     state  out  current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module pwm_deadtime_ch
  import pwm_pkg::*;
#(
  parameter int unsigned D = D_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef PWM_DEADTIME_FAULT_EN
  input  logic         trip,
  input  logic         clr,
`endif
  input  logic         pwm,
  input  logic [D-1:0] dead,
  output logic         hi,
  output logic         lo,
  output state_t       state
);

  state_t       state_nxt;
  logic [D-1:0] cnt;
  logic [D-1:0] cnt_nxt;
  logic         hi_d;
  logic         lo_d;
  logic         dead_zero;
  logic [D-1:0] dead_m1;

  assign dead_zero = (dead == '0);
  assign dead_m1   = dead - 1'b1;

  // State, counter and outputs all update on the same edge, so hi/lo are
  // pure flops decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= hi_d;
      lo    <= lo_d;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      // S_INIT commits to whichever side pwm asks for, always via the gap.
      S_INIT, S_LO, S_HI: begin
        if (pwm && (state != S_HI)) begin
          if (dead_zero) begin
            state_nxt = S_HI;
          end else begin
            state_nxt = S_DT_H;
            cnt_nxt   = dead_m1;
          end
        end else if (!pwm && (state != S_LO)) begin
          if (dead_zero) begin
            state_nxt = S_LO;
          end else begin
            state_nxt = S_DT_L;
            cnt_nxt   = dead_m1;
          end
        end
      end
      // An aborted pulse returns to the side that was on before; that side
      // never saw the opposite switch conduct, so no gap is needed.
      S_DT_H: begin
        if (!pwm) begin
          state_nxt = S_LO;
        end else if (cnt == '0) begin
          state_nxt = S_HI;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_DT_L: begin
        if (pwm) begin
          state_nxt = S_HI;
        end else if (cnt == '0) begin
          state_nxt = S_LO;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
`ifdef PWM_DEADTIME_FAULT_EN
      S_FAULT: begin
        if (clr) begin
          state_nxt = S_INIT;
        end
      end
`endif
      default: state_nxt = S_INIT;
    endcase
`ifdef PWM_DEADTIME_FAULT_EN
    if (trip) begin
      state_nxt = S_FAULT;
    end
`endif
  end

  always_comb begin
    hi_d = (state_nxt == S_HI);
    lo_d = (state_nxt == S_LO);
  end

endmodule

// File: rtl/pwm_deadtime.sv
// ---------------------------------------------------------------------------
// pwm_deadtime
//   N-channel dead-time inserter. Each bit of pwm drives an independent
//   channel producing complementary hi/lo gate enables; hi and lo of a
//   channel are never high together.
//
//   Optional feature macro: PWM_DEADTIME_FAULT_EN
//     Adds fault (async trip, double-flopped), fault_clr and fault_latched.
//     A synchronised fault forces every channel to S_FAULT; the latch is
//     released by fault_clr only once the synchronised fault is low.
//
//   Ports:
//     clk            in   system clock
//     rst_n          in   asynchronous active-low reset
//     pwm[N]         in   raw PWM bus, bit i is channel i
//     dead[D]        in   dead time in cycles, shared by all channels
//     fault          in   asynchronous trip (fault build only)
//     fault_clr      in   synchronous clear request (fault build only)
//     fault_latched  out  trip latch, registered (fault build only)
//     hi[N]          out  high-side enables, registered
//     lo[N]          out  low-side enables, registered
// ---------------------------------------------------------------------------
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned N = 1,
  parameter int unsigned D = D_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pwm,
  input  logic [D-1:0] dead,
`ifdef PWM_DEADTIME_FAULT_EN
  input  logic         fault,
  input  logic         fault_clr,
  output logic         fault_latched,
`endif
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

`ifdef PWM_DEADTIME_FAULT_EN
  logic fault_s1;
  logic fault_s2;
  logic clr_ok;

  // Clear is ignored while the synchronised fault is still high, so a
  // simultaneous fault and fault_clr keeps the trip latched.
  assign clr_ok = fault_clr & ~fault_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_s1      <= 1'b0;
      fault_s2      <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      fault_s1 <= fault;
      fault_s2 <= fault_s1;
      if (fault_s2) begin
        fault_latched <= 1'b1;
      end else if (clr_ok) begin
        fault_latched <= 1'b0;
      end
    end
  end
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t ch_state;

    pwm_deadtime_ch #(.D(D)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef PWM_DEADTIME_FAULT_EN
      .trip  (fault_s2),
      .clr   (clr_ok),
`endif
      .pwm   (pwm[i]),
      .dead  (dead),
      .hi    (hi[i]),
      .lo    (lo[i]),
      .state (ch_state)
    );
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// ---------------------------------------------------------------------------
// tb_pwm_deadtime
//   Directed bench for pwm_deadtime with N=4, D=8. Fault scenarios are
//   compiled in when PWM_DEADTIME_FAULT_EN is defined.
// ---------------------------------------------------------------------------
module tb_pwm_deadtime;

  localparam int unsigned N = 4;
  localparam int unsigned D = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] pwm;
  logic [D-1:0] dead;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
`ifdef PWM_DEADTIME_FAULT_EN
  logic         fault;
  logic         fault_clr;
  logic         fault_latched;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2*N-1:0] exp_q[$];

  pwm_deadtime #(.N(N), .D(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm           (pwm),
    .dead          (dead),
`ifdef PWM_DEADTIME_FAULT_EN
    .fault         (fault),
    .fault_clr     (fault_clr),
    .fault_latched (fault_latched),
`endif
    .hi            (hi),
    .lo            (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pwm   = '0;
    dead  = 8'd3;
`ifdef PWM_DEADTIME_FAULT_EN
    fault     = 1'b0;
    fault_clr = 1'b0;
`endif
    #3;
    tests_run++;
    if (hi !== 4'b0000 || lo !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_async hi=%b lo=%b expected hi=0000 lo=0000", hi, lo);
    end
    pwm = 4'b1010;
    tick();
    tick();
    tests_run++;
    if (hi !== 4'b0000 || lo !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_hold hi=%b lo=%b expected hi=0000 lo=0000", hi, lo);
    end
`ifdef PWM_DEADTIME_FAULT_EN
    tests_run++;
    if (fault_latched !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_latch fault_latched=%b expected 0", fault_latched);
    end
`endif
    pwm   = '0;
    rst_n = 1'b1;
  endtask

  // From S_INIT with pwm=0, dead=3: three gap cycles, then lo.
  task automatic test_init_entry();
    logic [3:0] exp_lo;
    exp_lo = 4'b1000;  // bit k = value after edge k+1
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (hi !== 4'b0000 || lo !== {N{exp_lo[k]}}) begin
        tests_failed++;
        $display("FAIL init_entry edge%0d hi=%b lo=%b expected hi=0000 lo=%b",
                 k + 1, hi, lo, {N{exp_lo[k]}});
      end
    end
  endtask

  // dead=3 rising then falling commutation on all channels.
  task automatic test_commutation();
    logic [4:0] exp_hi;
    logic [4:0] exp_lo;
    dead = 8'd3;
    pwm  = 4'b1111;
    exp_hi = 5'b11000;
    exp_lo = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if (hi !== {N{exp_hi[k]}} || lo !== {N{exp_lo[k]}} || (hi & lo) !== 4'b0000) begin
        tests_failed++;
        $display("FAIL rise_dt3 edge%0d hi=%b lo=%b expected hi=%b lo=%b",
                 k, hi, lo, {N{exp_hi[k]}}, {N{exp_lo[k]}});
      end
    end
    pwm = 4'b0000;
    exp_hi = 5'b00000;
    exp_lo = 5'b11000;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if (hi !== {N{exp_hi[k]}} || lo !== {N{exp_lo[k]}} || (hi & lo) !== 4'b0000) begin
        tests_failed++;
        $display("FAIL fall_dt3 edge%0d hi=%b lo=%b expected hi=%b lo=%b",
                 k, hi, lo, {N{exp_hi[k]}}, {N{exp_lo[k]}});
      end
    end
  endtask

  // dead=0: swap on every edge with no gap.
  task automatic test_zero_dead();
    logic [7:0] pat;
    pat  = 8'b01010101;
    dead = 8'd0;
    for (int k = 0; k < 8; k++) begin
      pwm = {N{pat[k]}};
      tick();
      tests_run++;
      if (hi !== {N{pat[k]}} || lo !== {N{~pat[k]}} || (hi & lo) !== 4'b0000) begin
        tests_failed++;
        $display("FAIL zero_dead edge%0d hi=%b lo=%b expected hi=%b lo=%b",
                 k, hi, lo, {N{pat[k]}}, {N{~pat[k]}});
      end
    end
    // Pattern ends with pwm=0, so channels are in S_LO.
  endtask

  // dead=5, two-cycle pulse is swallowed.
  task automatic test_short_pulse();
    logic [5:0] p;
    logic [5:0] exp_lo;
    dead   = 8'd5;
    p      = 6'b000011;
    exp_lo = 6'b111100;
    for (int k = 0; k < 6; k++) begin
      pwm = {N{p[k]}};
      tick();
      tests_run++;
      if (hi !== 4'b0000 || lo !== {N{exp_lo[k]}}) begin
        tests_failed++;
        $display("FAIL short_pulse edge%0d hi=%b lo=%b expected hi=0000 lo=%b",
                 k, hi, lo, {N{exp_lo[k]}});
      end
    end
  endtask

  // Independent channels; dead changes 4->1 while ch0 is counting.
  task automatic test_multi_channel();
    logic [N-1:0] stim_pwm  [7];
    logic [D-1:0] stim_dead [7];
    logic [2*N-1:0] got;
    logic [2*N-1:0] exp;
    stim_pwm  = '{4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b1100, 4'b1100};
    stim_dead = '{8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    // {hi, lo} after each edge
    exp_q.push_back({4'b0000, 4'b1110});
    exp_q.push_back({4'b0000, 4'b1010});
    exp_q.push_back({4'b0100, 4'b1010});
    exp_q.push_back({4'b0100, 4'b1010});
    exp_q.push_back({4'b0101, 4'b1010});
    exp_q.push_back({4'b0100, 4'b0010});
    exp_q.push_back({4'b1100, 4'b0011});
    for (int k = 0; k < 7; k++) begin
      pwm  = stim_pwm[k];
      dead = stim_dead[k];
      tick();
      got = {hi, lo};
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp || (hi & lo) !== 4'b0000) begin
        tests_failed++;
        $display("FAIL multi_ch edge%0d hi=%b lo=%b expected hi=%b lo=%b",
                 k, hi, lo, exp[2*N-1:N], exp[N-1:0]);
      end
    end
  endtask

`ifdef PWM_DEADTIME_FAULT_EN
  task automatic test_fault();
    dead = 8'd0;
    pwm  = 4'b1111;
    tick();
    tests_run++;
    if (hi !== 4'b1111 || lo !== 4'b0000) begin
      tests_failed++;
      $display("FAIL fault_pre hi=%b lo=%b expected hi=1111 lo=0000", hi, lo);
    end
    fault = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++;
      if (hi !== 4'b1111 || fault_latched !== 1'b0) begin
        tests_failed++;
        $display("FAIL fault_sync edge%0d hi=%b latched=%b expected hi=1111 latched=0",
                 k, hi, fault_latched);
      end
    end
    tick();
    tests_run++;
    if (hi !== 4'b0000 || lo !== 4'b0000 || fault_latched !== 1'b1) begin
      tests_failed++;
      $display("FAIL fault_trip hi=%b lo=%b latched=%b expected hi=0000 lo=0000 latched=1",
               hi, lo, fault_latched);
    end
    fault_clr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests_run++;
      if (hi !== 4'b0000 || lo !== 4'b0000 || fault_latched !== 1'b1) begin
        tests_failed++;
        $display("FAIL fault_clr_blocked edge%0d hi=%b lo=%b latched=%b expected latched=1 outs 0",
                 k, hi, lo, fault_latched);
      end
    end
    fault     = 1'b0;
    fault_clr = 1'b0;
    tick();
    tick();
    tests_run++;
    if (fault_latched !== 1'b1 || hi !== 4'b0000 || lo !== 4'b0000) begin
      tests_failed++;
      $display("FAIL fault_hold latched=%b hi=%b lo=%b expected latched=1 outs 0",
               fault_latched, hi, lo);
    end
    fault_clr = 1'b1;
    tick();
    tests_run++;
    if (fault_latched !== 1'b0 || hi !== 4'b0000 || lo !== 4'b0000) begin
      tests_failed++;
      $display("FAIL fault_clear latched=%b hi=%b lo=%b expected latched=0 outs 0",
               fault_latched, hi, lo);
    end
    fault_clr = 1'b0;
    dead      = 8'd2;
    pwm       = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (k < 2) begin
        if (hi !== 4'b0000 || lo !== 4'b0000) begin
          tests_failed++;
          $display("FAIL fault_reentry_gap edge%0d hi=%b lo=%b expected hi=0000 lo=0000",
                   k, hi, lo);
        end
      end else begin
        if (hi !== 4'b0001 || lo !== 4'b1110) begin
          tests_failed++;
          $display("FAIL fault_reentry hi=%b lo=%b expected hi=0001 lo=1110", hi, lo);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_init_entry();
    test_commutation();
    test_zero_dead();
    test_short_pulse();
    test_multi_channel();
`ifdef PWM_DEADTIME_FAULT_EN
    test_fault();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
